// File: rtl/regfile_dump.sv
// Debug-side register-file dumper: walks FIRST_REG..LAST_REG on the debug read port and
// streams each word MSB byte first as UART 8N1. Define REGDUMP_HEADER_EN to prefix each word with its index.
module regfile_dump #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIRST_REG    = 0,
  parameter int unsigned LAST_REG     = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  ra_debug,
  input  logic [31:0] ra_debug_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

`ifdef REGDUMP_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    IDX_FIRST = 5'(FIRST_REG);
  localparam logic [4:0]    IDX_LAST  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPTURE,
    S_START_BIT,
    S_DATA_BIT,
    S_STOP_BIT,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [1:0]      byte_cnt;
  logic [31:0]     word;
  logic [7:0]      shreg;
  logic            hdr;
  logic            bit_end;

  assign bit_end = (bit_cnt == BIT_LAST);

  // Sequencer, datapath and registered outputs in one process.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= 3'd0;
      byte_cnt <= 2'd0;
      word     <= 32'd0;
      shreg    <= 8'd0;
      hdr      <= 1'b0;
      ra_debug <= 5'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ra_debug <= IDX_FIRST;
            busy     <= 1'b1;
            state    <= S_ADDR;
          end
        end

        // Word is latched on the edge leaving ADDR, one cycle after the index was driven.
        S_ADDR: begin
          word     <= ra_debug_data;
          byte_cnt <= 2'd0;
          hdr      <= HDR_EN;
          state    <= S_CAPTURE;
        end

        S_CAPTURE: begin
          if (hdr) begin
            shreg <= {3'b000, ra_debug};
          end else begin
            shreg <= word[31:24];
            word  <= {word[23:0], 8'h00};
          end
          bit_cnt <= '0;
          tx      <= 1'b0;
          state   <= S_START_BIT;
        end

        S_START_BIT: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= S_DATA_BIT;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        S_DATA_BIT: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        // The header byte does not advance the data byte count.
        S_STOP_BIT: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (hdr || (byte_cnt != 2'd3)) begin
              if (!hdr) begin
                byte_cnt <= byte_cnt + 2'd1;
              end
              hdr   <= 1'b0;
              shreg <= word[31:24];
              word  <= {word[23:0], 8'h00};
              tx    <= 1'b0;
              state <= S_START_BIT;
            end else if (ra_debug != IDX_LAST) begin
              ra_debug <= ra_debug + 5'd1;
              state    <= S_ADDR;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a single-register instance (5..5) and a full-range
// instance (0..31) share clock, reset and a behavioural register file; a UART receiver decodes tx.
`timescale 1ns/1ps
module tb_regfile_dump;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
`ifdef REGDUMP_HEADER_EN
  localparam int B = 5;
`else
  localparam int B = 4;
`endif
  // Dump length in cycles, counted from the start-sampling cycle through the done cycle.
  localparam int SINGLE_CYC = 2 + 1  * (B * FRAME + 2);
  localparam int FULL_CYC   = 2 + 32 * (B * FRAME + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_s = 1'b0;
  logic        start_f = 1'b0;
  logic [4:0]  ra_s, ra_f;
  logic [31:0] data_s, data_f;
  logic        tx_s, tx_f, busy_s, busy_f, done_s, done_f;
  logic [31:0] rf [32];
  logic [7:0]  exp_s [5];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data_s = rf[ra_s];
  assign data_f = rf[ra_f];

  regfile_dump #(.CLKS_PER_BIT(CPB), .FIRST_REG(5), .LAST_REG(5)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .ra_debug(ra_s), .ra_debug_data(data_s),
    .tx(tx_s), .busy(busy_s), .done(done_s)
  );

  regfile_dump #(.CLKS_PER_BIT(CPB), .FIRST_REG(0), .LAST_REG(31)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .ra_debug(ra_f), .ra_debug_data(data_f),
    .tx(tx_f), .busy(busy_f), .done(done_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic txv(input bit which);
    return which ? tx_f : tx_s;
  endfunction

  // Waits (bounded) for a start bit, samples each bit mid-period, checks framing.
  task automatic rx_byte(input bit which, output logic [7:0] b, output int t_start);
    int waited = 0;
    b = 8'h00;
    t_start = -1;
    while (txv(which) !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (txv(which) !== 1'b0) begin
      check("rx_start_timeout", 32'(txv(which)), 32'd0);
      return;
    end
    t_start = cyc;
    repeat (2) @(negedge clk);
    check("rx_start_bit", 32'(txv(which)), 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      b[k] = txv(which);
    end
    repeat (CPB) @(negedge clk);
    check("rx_stop_bit", 32'(txv(which)), 32'd1);
  endtask

  // One dump on the single-register instance; optionally pokes start in the middle of byte 2.
  task automatic run_single(input bit poke);
    int e0, td, ts;
    logic [7:0] b;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    e0 = cyc;
    check("s_busy_e0", 32'(busy_s), 32'd1);
    check("s_ra_e0", 32'(ra_s), 32'd5);
    check("s_tx_e0", 32'(tx_s), 32'd1);
    fork
      begin
        for (int j = 0; j < B; j++) begin
          rx_byte(1'b0, b, ts);
          check($sformatf("s_byte%0d", j), 32'(b), 32'(exp_s[j]));
          check($sformatf("s_byte%0d_start", j), 32'(ts - e0), 32'(2 + j * FRAME));
        end
      end
      begin
        if (poke) begin
          repeat (91) @(negedge clk);
          start_s = 1'b1;
          @(negedge clk);
          start_s = 1'b0;
        end
      end
    join
    td = -1;
    for (int k = 0; k < 40 && td < 0; k++) begin
      if (done_s === 1'b1) td = cyc;
      else @(negedge clk);
    end
    check("s_done_cycles", 32'(td - e0 + 2), 32'(SINGLE_CYC));
    check("s_busy_at_done", 32'(busy_s), 32'd0);
    @(negedge clk);
    check("s_done_pulse_width", 32'(done_s), 32'd0);
    check("s_busy_after", 32'(busy_s), 32'd0);
    check("s_ra_hold", 32'(ra_s), 32'd5);
    check("s_tx_idle", 32'(tx_s), 32'd1);
  endtask

  initial begin
    int e0, td, ts;
    logic [7:0] b;

    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
    rf[5] = 32'hDEADBEEF;
`ifdef REGDUMP_HEADER_EN
    exp_s[0] = 8'h05; exp_s[1] = 8'hDE; exp_s[2] = 8'hAD; exp_s[3] = 8'hBE; exp_s[4] = 8'hEF;
`else
    exp_s[0] = 8'hDE; exp_s[1] = 8'hAD; exp_s[2] = 8'hBE; exp_s[3] = 8'hEF; exp_s[4] = 8'h00;
`endif

    // Reset held 3 cycles with start pulses that must be ignored.
    start_s = 1'b1;
    start_f = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_s", 32'(tx_s), 32'd1);
    check("rst_busy_s", 32'(busy_s), 32'd0);
    check("rst_done_s", 32'(done_s), 32'd0);
    check("rst_ra_s", 32'(ra_s), 32'd0);
    check("rst_tx_f", 32'(tx_f), 32'd1);
    check("rst_busy_f", 32'(busy_f), 32'd0);
    check("rst_ra_f", 32'(ra_f), 32'd0);
    start_s = 1'b0;
    start_f = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy_s", 32'(busy_s), 32'd0);
    check("post_rst_tx_s", 32'(tx_s), 32'd1);

    // Single register, then the same with a start poke while busy.
    run_single(1'b0);
    run_single(1'b1);

    // Full 0..31 dump.
    rf[5] = 32'h05050505;
    @(negedge clk);
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    e0 = cyc;
    check("f_busy_e0", 32'(busy_f), 32'd1);
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < B; j++) begin
        rx_byte(1'b1, b, ts);
        if (j == 0) check($sformatf("f_ra_r%0d", i), 32'(ra_f), 32'(i));
        check($sformatf("f_byte_r%0d_b%0d", i, j), 32'(b), 32'(i));
      end
    end
    td = -1;
    for (int k = 0; k < 40 && td < 0; k++) begin
      if (done_f === 1'b1) td = cyc;
      else @(negedge clk);
    end
    check("f_done_cycles", 32'(td - e0 + 2), 32'(FULL_CYC));
    @(negedge clk);
    check("f_ra_hold", 32'(ra_f), 32'd31);
    check("f_busy_after", 32'(busy_f), 32'd0);

    // Reset mid-frame during data bit 5 (a 0 bit for both 0xDE and 0x05).
    rf[5] = 32'hDEADBEEF;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    e0 = cyc;
    repeat (27) @(negedge clk);
    check("mid_tx_before_rst", 32'(tx_s), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx_s), 32'd1);
    check("mid_rst_busy", 32'(busy_s), 32'd0);
    check("mid_rst_ra", 32'(ra_s), 32'd0);
    check("mid_rst_done", 32'(done_s), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_single(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug-side reader for the processor's register-file debug port. On a start pulse it walks a configured range of register indices on `ra_debug`, captures each `ra_debug_data` word, and serializes it over a UART 8N1 transmit line, most-significant byte first. It sits beside the processor top on the debug path and lets a host dump architectural state without halting the core.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit; 100 MHz / 115200 baud; legal minimum 2.
- `FIRST_REG`, default 0: first register index dumped, range 0–31.
- `LAST_REG`, default 31: last register index dumped, range 0–31, and `LAST_REG` ≥ `FIRST_REG`.

**Ports**
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a dump; sampled only in IDLE.
- `ra_debug`, output, 5: register index driven to the processor debug port.
- `ra_debug_data`, input, 32: combinational register read for `ra_debug`.
- `tx`, output, 1: UART serial output; idle high.
- `busy`, output, 1: high from the accepted start until the dump completes.
- `done`, output, 1: one-cycle pulse on completion.

## Operation

**States:** IDLE, ADDR, CAPTURE, START_BIT, DATA_BIT, STOP_BIT, DONE.

- **IDLE**
  - `start`=1 → ADDR; index ← `FIRST_REG`; `busy` ← 1.
  - `start` is ignored in every other state; no restart and no queuing.
- **ADDR:** `ra_debug` = index; the read settles → CAPTURE.
- **CAPTURE:** 32-bit shift register ← `ra_debug_data`; byte counter ← 0 → START_BIT.
  - The word is sampled exactly once; later changes on `ra_debug_data` do not affect bytes already captured.
- **Byte selection:** byte k (k = 0..3) = word[31-8k : 24-8k].
- **START_BIT:** `tx`=0 for `CLKS_PER_BIT` cycles → DATA_BIT.
- **DATA_BIT:** eight bits, LSB first, each held `CLKS_PER_BIT` cycles → STOP_BIT.
- **STOP_BIT:** `tx`=1 for `CLKS_PER_BIT` cycles, then:
  - byte counter < 3 → START_BIT of the next byte, with no extra idle gap;
  - byte counter = 3 and index < `LAST_REG` → index+1, → ADDR;
  - byte counter = 3 and index = `LAST_REG` → DONE.
- **DONE:** `done`=1 and `busy`=0 for exactly one cycle → IDLE.
- **Counters:**
  - bit-period counter width = $clog2(`CLKS_PER_BIT`);
  - bit index is 3 bits;
  - byte counter is 2 bits;
  - register index is 5 bits and never wraps past `LAST_REG`.
- **Register 0** is dumped as read; it is expected to be 0x00000000.
- **Output rules:**
  - `tx` is driven from a register, so it is glitch-free;
  - `tx`=1 in IDLE, ADDR, CAPTURE and DONE;
  - `ra_debug` holds its last index after the dump; it returns to 0 only on reset.

## Timing

- **Reset values:** `tx`=1, `busy`=0, `done`=0, `ra_debug`=0; state IDLE.
- **Reset asserted mid-operation:** outputs go to their reset values immediately (asynchronous reset), even mid-bit. The partial frame is abandoned.
- **After reset release:** the block waits in IDLE for a new `start`, and a new dump restarts from `FIRST_REG`.
- **Start latency:** let E0 be the edge that samples `start`=1 in IDLE.
  - `busy` and `ra_debug` are valid after E0.
  - Capture occurs at E1.
  - `tx` falls after E2.
- **Byte frame:** 10 × `CLKS_PER_BIT` cycles.
- **Gap between registers:** 2 cycles with `tx`=1 (ADDR, CAPTURE).
- **Dump length:** N = `LAST_REG`−`FIRST_REG`+1 registers. The dump takes 2 + N×(B×10×`CLKS_PER_BIT`+2) cycles from E0 to the `done` pulse, where B = bytes per register.
- **`start` and `done`:** if `start` is high in the DONE cycle, it is ignored; it is accepted on the next IDLE cycle.

## Configuration

- **`REGDUMP_HEADER_EN` defined:**
  - each register is preceded by a header byte {3'b000, index};
  - B = 5, and the header is sent before byte 0;
  - the header is sent immediately after CAPTURE.
- **`REGDUMP_HEADER_EN` undefined:**
  - no header; B = 4;
  - the byte counter stays 2 bits.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and a behavioural register-file model on `ra_debug`/`ra_debug_data`.

1. **Reset:** hold `rst`=0 for 3 cycles → `tx`=1, `busy`=0, `done`=0, `ra_debug`=0; `start` pulses during reset are ignored.
2. **Single register:** `FIRST_REG`=`LAST_REG`=5, r5=0xDEADBEEF, one start pulse → bytes 0xDE, 0xAD, 0xBE, 0xEF with a correct 8N1 frame each; `done` is a 1-cycle pulse 164 cycles after E0 (2 + 4×40 + 2).
3. **Full dump:** 0..31 with r_i = i×0x01010101 → 128 bytes; `ra_debug` steps 0..31; the first four bytes are 0x00; the last four are 0x1F.
4. **Start while busy:** pulse `start` in the middle of byte 2 → the byte stream and `done` timing are identical to scenario 2.
5. **Reset mid-dump:** drive `rst` low during a DATA_BIT → `tx`=1 and `busy`=0 in the same cycle; after release and a new start, the stream begins again at `FIRST_REG`.
6. **Header feature:** with `REGDUMP_HEADER_EN`, `FIRST_REG`=`LAST_REG`=5, r5=0xDEADBEEF → bytes 0x05, 0xDE, 0xAD, 0xBE, 0xEF; `done` 204 cycles after E0.
